// File: rtl/layer_act_fifo.sv
// layer_act_fifo: elastic activation FIFO with bypassable output register; LAYER_ACT_FIFO_FRAME_CNT_EN builds the frame_done counter
module layer_act_fifo #(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 9,
  parameter int DEPTH     = 512,
  parameter int FRAME_LEN = 100352
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [DWIDTH-1:0] reluRes_V_V_TDATA,
  input  logic              reluRes_V_V_TVALID,
  output logic              reluRes_V_V_TREADY,
  output logic [DWIDTH-1:0] ActDMA_V_V_TDATA,
  output logic              ActDMA_V_V_TVALID,
  input  logic              ActDMA_V_V_TREADY,
  output logic [AWIDTH:0]   count,
  output logic              frame_done
);
  logic [DWIDTH-1:0] ram [0:DEPTH-2];
  logic [AWIDTH-1:0] wrPtr, rdPtr;
  logic push, pop, outFree, ramEmpty, refill, bypass;
  function automatic logic [AWIDTH-1:0] nextPtr(input logic [AWIDTH-1:0] p);
    return p == AWIDTH'(DEPTH - 2) ? '0 : p + 1'b1;
  endfunction
  assign reluRes_V_V_TREADY = count != (AWIDTH+1)'(DEPTH);
  assign push = reluRes_V_V_TVALID && reluRes_V_V_TREADY;
  assign pop = ActDMA_V_V_TVALID && ActDMA_V_V_TREADY;
  assign outFree = !ActDMA_V_V_TVALID || pop;
  // the output register counts toward occupancy, so the RAM is empty when count equals its valid bit
  assign ramEmpty = count == {{AWIDTH{1'b0}}, ActDMA_V_V_TVALID};
  assign refill = outFree && !ramEmpty;
  assign bypass = push && outFree && ramEmpty;
  always_ff @(posedge ap_clk)
    if (push && !bypass) ram[wrPtr] <= reluRes_V_V_TDATA;
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      ActDMA_V_V_TVALID <= 1'b0;
      ActDMA_V_V_TDATA <= '0;
      count <= '0;
    end else begin
      if (push && !bypass) wrPtr <= nextPtr(wrPtr);
      if (refill) rdPtr <= nextPtr(rdPtr);
      if (refill || bypass) begin
        ActDMA_V_V_TVALID <= 1'b1;
        ActDMA_V_V_TDATA <= refill ? ram[rdPtr] : reluRes_V_V_TDATA;
      end else if (pop) ActDMA_V_V_TVALID <= 1'b0;
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    end
`ifdef LAYER_ACT_FIFO_FRAME_CNT_EN
  localparam int FW = $clog2(FRAME_LEN);
  logic [FW-1:0] frameCnt;
  logic frameLast;
  assign frameLast = frameCnt == FW'(FRAME_LEN - 1);
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) begin
      frameCnt <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop && frameLast;
      if (pop) frameCnt <= frameLast ? '0 : frameCnt + 1'b1;
    end
`else
  assign frame_done = 1'b0;
`endif
endmodule

// File: tb/tb_layer_act_fifo.sv
// tb_layer_act_fifo: randomized scoreboard bench for layer_act_fifo against a queue model
module tb_layer_act_fifo;
  localparam int DW = 8;
  localparam int AW = 9;
  localparam int DEPTH = 512;
  localparam int FL = 16;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic [DW-1:0] inData = '0;
  logic inValid = 1'b0;
  logic inReady;
  logic [DW-1:0] outData;
  logic outValid;
  logic outReady = 1'b0;
  logic [AW:0] count;
  logic frameDone;
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] q[$];
  int pops = 0;
  bit expDone = 1'b0;
  bit holdPrev = 1'b0;
  logic [DW-1:0] prevData = '0;
  int doneSeen = 0;

  layer_act_fifo #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .FRAME_LEN(FL)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .reluRes_V_V_TDATA(inData), .reluRes_V_V_TVALID(inValid), .reluRes_V_V_TREADY(inReady),
    .ActDMA_V_V_TDATA(outData), .ActDMA_V_V_TVALID(outValid), .ActDMA_V_V_TREADY(outReady),
    .count(count), .frame_done(frameDone));

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: occupancy is the queue size; a push is accepted only below DEPTH, a pop only when non-empty
  always @(negedge ap_clk) begin
    bit push, pop;
    if (ap_rst) begin
      q.delete();
      pops = 0;
      expDone = 1'b0;
      holdPrev = 1'b0;
    end else begin
      push = inValid && q.size() != DEPTH;
      pop = q.size() != 0 && outReady;
      chk("count", 32'(count), 32'(q.size()));
      chk("in_tready", 32'(inReady), 32'(q.size() != DEPTH));
      chk("out_tvalid", 32'(outValid), 32'(q.size() != 0));
      chk("frame_done", 32'(frameDone), 32'(expDone));
      if (frameDone) doneSeen++;
      if (holdPrev) chk("hold_stable", 32'(outData), 32'(prevData));
      if (pop) chk("out_data", 32'(outData), 32'(q.pop_front()));
      if (push) q.push_back(inData);
      holdPrev = outValid && !outReady;
      prevData = outData;
`ifdef LAYER_ACT_FIFO_FRAME_CNT_EN
      if (pop) pops = (pops + 1) % FL;
      expDone = pop && pops == 0;
`else
      expDone = 1'b0;
`endif
    end
  end

  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r);
    inValid = v;
    inData = d;
    outReady = r;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) cyc(1'b0, '0, 1'b1);
    chk("drain_timeout", 32'(q.size()), 0);
  endtask

  initial begin
    #1;
    chk("rst_tvalid", 32'(outValid), 0);
    chk("rst_tdata", 32'(outData), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_tready", 32'(inReady), 1);
    chk("rst_frame_done", 32'(frameDone), 0);
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    cyc(1'b1, 8'hA5, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'hEE, 1'b0);
    cyc(1'b1, 8'h77, 1'b1);
    drain();
    for (int i = 0; i < 1000; i++) cyc(1'b1, 8'(i), 1'b1);
    drain();
    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0));
    for (int i = 0; i < 1500; i++)
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    drain();
    for (int i = 0; i < 37; i++) cyc(1'b1, 8'($urandom), 1'b0);
    inValid = 1'b0;
    #2;
    ap_rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", 32'(outValid), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_tready", 32'(inReady), 1);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    doneSeen = 0;
    cyc(1'b1, 8'h3C, 1'b0);
    chk("first_after_rst", 32'(outData), 32'h3C);
    for (int i = 1; i < 40; i++) cyc(1'b1, 8'(i), 1'b1);
    drain();
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
`ifdef LAYER_ACT_FIFO_FRAME_CNT_EN
    chk("frame_pulses", 32'(doneSeen), 2);
`else
    chk("frame_pulses", 32'(doneSeen), 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/layer_act_fifo.md
# layer_act_fifo

Elastic activation buffer between consecutive MobileNetV1 layer stages. It accepts the 8-bit ReLU output stream of one layer, for example Layer9's reluRes stream, and presents it as the 8-bit activation DMA stream of the next layer. This decouples the producer PE's bursty output from the consumer's WriteAct loader. It also optionally counts output bytes per feature map and flags frame completion.

## Interface
Parameters:
- DWIDTH, 8, stream data width
- AWIDTH, 9, log2 of storage depth
- DEPTH, 512, total capacity in words, including the output register; must equal 2**AWIDTH
- FRAME_LEN, 100352, bytes per output feature map (14x14x512)

Ports:
- ap_clk  in  1  sole clock; all logic is rising-edge
- ap_rst  in  1  asynchronous, active-high reset
- reluRes_V_V_TDATA  in  DWIDTH  input activation byte
- reluRes_V_V_TVALID  in  1  input valid
- reluRes_V_V_TREADY  out  1  input ready
- ActDMA_V_V_TDATA  out  DWIDTH  output activation byte
- ActDMA_V_V_TVALID  out  1  output valid
- ActDMA_V_V_TREADY  in  1  output ready
- count  out  AWIDTH+1  current occupancy, 0..DEPTH
- frame_done  out  1  one-cycle pulse after the last byte of a frame leaves

## Operation
- Structure: a DEPTH-1 entry circular RAM with AWIDTH-bit write and read pointers, plus one output register that drives the ActDMA port.
- push: reluRes TVALID && TREADY. pop: ActDMA TVALID && TREADY.
- reluRes_V_V_TREADY = (count != DEPTH). This is combinational from registered count only.
- A push is never accepted while full, even if a pop occurs in the same cycle.
- ActDMA_V_V_TVALID is high exactly when the output register holds data.
- Write path:
  - If the output register is empty, or is being popped this cycle, and the RAM is empty, the pushed byte loads the output register directly (bypass).
  - Otherwise the pushed byte is written at wr_ptr, and wr_ptr increments.
- Refill: when the output register is empty or popped and the RAM is non-empty, RAM[rd_ptr] loads the output register and rd_ptr increments. The read is same-cycle (distributed/async read). Refill takes priority over bypass, which preserves order.
- Pointers wrap modulo 2**AWIDTH−1 entries: they reset to 0 after index DEPTH-2.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Output TDATA is held stable while TVALID is high and TREADY is low (AXI-stream rule).
- Frame counter (when compiled in):
  - Counts pops, 0..FRAME_LEN-1.
  - A pop at FRAME_LEN-1 wraps the counter to 0 and sets frame_done high for the next cycle only.

## Timing
- Reset values:
  - reluRes_V_V_TREADY=1
  - ActDMA_V_V_TVALID=0
  - ActDMA_V_V_TDATA=0
  - count=0
  - frame_done=0
  - pointers=0
  - frame counter=0
- Reset asserted mid-operation: all contents are discarded and all outputs return to reset values immediately (asynchronous).
- Latency, empty FIFO: a byte pushed in cycle N appears on ActDMA with TVALID=1 in cycle N+1.
- Throughput: 1 byte/cycle sustained when both sides are ready.
- Full boundary: count reaches DEPTH when the RAM holds DEPTH-1 words and the output register is occupied. TREADY falls in the following cycle.
- Empty boundary: a pop of the last word with no concurrent push sets TVALID=0 in the next cycle.
- Simultaneous push and pop when count=1: the pushed byte bypasses into the output register and TVALID stays 1.

## Configuration
- LAYER_ACT_FIFO_FRAME_CNT_EN:
  - Defined: the frame counter (ceil(log2(FRAME_LEN)) bits) and the frame_done logic are built.
  - Undefined: no counter logic; frame_done is tied to 0.
- FIFO behaviour is identical in both builds.

## Test plan
- Reset, then 1 push of 0xA5 with out TREADY=1 -> TVALID=1 with TDATA=0xA5 one cycle later, popped; count 0→1→0.
- Out TREADY=0, push 512 bytes 0x00..0xFF repeating -> count=512 and in TREADY=0. Then release TREADY -> all 512 bytes emerge in order, no gaps, with in TREADY returning 1 the cycle after the first pop.
- Both sides continuously valid/ready for 1000 bytes of an incrementing pattern -> output equals input, 1 byte/cycle, count stays at 1.
- Out TREADY held 0 with TVALID=1 for 5 cycles -> TDATA unchanged; count=512 with a concurrent pop -> that push is not accepted.
- Assert ap_rst with count=37 -> immediately TVALID=0, count=0, TREADY=1. The next push, 0x3C, is the first output.
- With LAYER_ACT_FIFO_FRAME_CNT_EN and FRAME_LEN=16, stream 40 bytes -> frame_done pulses for exactly 1 cycle after pops 16 and 32, with no pulse after pop 40. Without the macro, frame_done stays 0.
